// File: rtl/fulladder_pkg.sv
// fulladder_pkg: shared constants for the three-operand adder
package fulladder_pkg;
  localparam int FA_DEFAULT_WIDTH = 4;
endpackage

// File: rtl/fulladder_fa_cell.sv
// fa_cell: purely combinational 1-bit full adder
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/fulladder.sv
// fulladder: registered a+b+cin via a carry-save row feeding a ripple row
module fulladder
  import fulladder_pkg::*;
#(
  parameter int WIDTH = FA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  logic [WIDTH-1:0] cs_s;
  logic [WIDTH-1:0] cs_c;
  logic [WIDTH:0]   x;
  logic [WIDTH:0]   y;
  logic [WIDTH:0]   r;
  logic [WIDTH+1:0] rc;
  for (genvar i = 0; i < WIDTH; i++) begin : g_csa
    fa_cell u_csa (.a(a[i]), .b(b[i]), .ci(cin[i]), .s(cs_s[i]), .co(cs_c[i]));
  end
  assign x     = {1'b0, cs_s};
  assign y     = {cs_c, 1'b0};
  assign rc[0] = 1'b0;
  for (genvar i = 0; i <= WIDTH; i++) begin : g_rca
    fa_cell u_rca (.a(x[i]), .b(y[i]), .ci(rc[i]), .s(r[i]), .co(rc[i+1]));
  end
  // Output register: clear on reset, otherwise capture the low bits and overflow of the total
  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= '0;
      carry <= 1'b0;
    end else begin
      sum   <= r[WIDTH-1:0];
      carry <= r[WIDTH] | rc[WIDTH+1];
    end
  end
endmodule

// File: tb/tb_fulladder.sv
// tb_fulladder: random and directed checks of fulladder against an arithmetic model
module tb_fulladder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic [3:0] cin = '0;
  logic [3:0] sum;
  logic       carry;
  int         checks = 0;
  int         failures = 0;
  logic       lit_on = 1'b0;
  logic [3:0] lit_s = '0;
  logic       lit_c = 1'b0;
  string      lit_name = "";

  fulladder #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .sum(sum), .carry(carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Model + compare: capture inputs at each rising edge, check outputs at the following falling edge
  initial begin
    logic       m_valid;
    int         total;
    logic       m_lit;
    logic [3:0] m_ls;
    logic       m_lc;
    string      m_name;
    m_valid = 1'b0;
    forever begin
      @(posedge clk);
      m_valid = m_valid | rst;
      total   = rst ? 0 : int'(a) + int'(b) + int'(cin);
      m_lit   = lit_on;
      m_ls    = lit_s;
      m_lc    = lit_c;
      m_name  = lit_name;
      @(negedge clk);
      if (m_valid) begin
        chk("model_sum", {28'd0, sum}, total % 16);
        chk("model_carry", {31'd0, carry}, (total > 15) ? 1 : 0);
        if (m_lit) begin
          chk({m_name, "_sum"}, {28'd0, sum}, {28'd0, m_ls});
          chk({m_name, "_carry"}, {31'd0, carry}, {31'd0, m_lc});
        end
      end
    end
  end

  task automatic apply(input logic [3:0] ta, input logic [3:0] tb, input logic [3:0] tc,
                       input logic tr, input logic tl, input logic [3:0] es,
                       input logic ec, input string n);
    a = ta; b = tb; cin = tc; rst = tr;
    lit_on = tl; lit_s = es; lit_c = ec; lit_name = n;
    @(posedge clk);
    #1;
  endtask

  initial begin
    apply(4'hF, 4'hA, 4'h7, 1'b1, 1'b1, 4'h0, 1'b0, "reset");
    apply(4'h3, 4'h4, 4'h1, 1'b0, 1'b1, 4'h8, 1'b0, "basic");
    apply(4'hF, 4'h1, 4'h0, 1'b0, 1'b1, 4'h0, 1'b1, "pow2");
    apply(4'hF, 4'hF, 4'hF, 1'b0, 1'b1, 4'hD, 1'b1, "all_ones");
    apply(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, "zeros");
    apply(4'h1, 4'h1, 4'h1, 1'b0, 1'b1, 4'h3, 1'b0, "b2b_0");
    apply(4'h8, 4'h8, 4'h0, 1'b0, 1'b1, 4'h0, 1'b1, "b2b_1");
    apply(4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, "b2b_2");
    apply(4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 4'h0, 1'b0, "mid_reset");
    apply(4'hF, 4'hF, 4'hF, 1'b0, 1'b1, 4'hD, 1'b1, "post_reset");
    apply(4'h0, 4'hF, 4'h1, 1'b0, 1'b1, 4'h0, 1'b1, "pow2_b");
    apply(4'h7, 4'h5, 4'h3, 1'b0, 1'b1, 4'hF, 1'b0, "max_no_carry");
    for (int i = 0; i < 1000; i++)
      apply(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 19) == 0), 1'b0, 4'h0, 1'b0, "rand");
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
